// File: rtl/wb_cplx_holding_buffer.sv
// Complex-lane writeback holding FIFO in front of the simple/complex writeback mux.
// Optional same-cycle bypass when empty: define WB_HOLD_BYPASS_EN.
module wb_cplx_holding_buffer #(
  parameter int PKT_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       simple_valid_i,
  input  logic                       cplx_valid_i,
  input  logic [PKT_W-1:0]           cplx_pkt_i,
  output logic                       cplx_ready_o,
  output logic                       wb_valid_o,
  output logic [PKT_W-1:0]           wb_pkt_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             has_data, bypass, push, pop, violation;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign has_data     = (count != '0);
  assign cplx_ready_o = (count < CNT_W'(DEPTH));

`ifdef WB_HOLD_BYPASS_EN
  // Empty buffer and free port: hand the packet straight to the mux.
  assign bypass = reset_n & ~has_data & cplx_valid_i & ~simple_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign push      = cplx_valid_i & cplx_ready_o & ~flush_i & ~bypass;
  assign pop       = has_data & ~flush_i & ~simple_valid_i;
  assign violation = cplx_valid_i & ~cplx_ready_o;

  assign wb_valid_o = (has_data & ~flush_i) | bypass;
  assign wb_pkt_o   = bypass ? cplx_pkt_i : (has_data ? mem[rd_ptr] : '0);
  assign count_o    = count;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cplx_pkt_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky until reset; a flush does not clear a recorded violation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       overflow_o <= 1'b0;
    else if (violation) overflow_o <= 1'b1;
  end
endmodule

// File: tb/tb_wb_cplx_holding_buffer.sv
// Self-checking bench for wb_cplx_holding_buffer against a queue-based reference model.
module tb_wb_cplx_holding_buffer;
  localparam int PKT_W = 64;
  localparam int DEPTH = 4;

  logic             clk, reset_n, flush_i, simple_valid_i, cplx_valid_i;
  logic [PKT_W-1:0] cplx_pkt_i, wb_pkt_o;
  logic             cplx_ready_o, wb_valid_o, overflow_o;
  logic [2:0]       count_o;

  wb_cplx_holding_buffer #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .simple_valid_i(simple_valid_i),
    .cplx_valid_i(cplx_valid_i), .cplx_pkt_i(cplx_pkt_i), .cplx_ready_o(cplx_ready_o),
    .wb_valid_o(wb_valid_o), .wb_pkt_o(wb_pkt_o), .count_o(count_o), .overflow_o(overflow_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model state and per-cycle expectations
  logic [PKT_W-1:0] q[$];
  bit               m_ovf;
  bit               e_valid, e_ready, e_ovf, e_byp;
  logic [PKT_W-1:0] e_pkt;
  logic [2:0]       e_count;

  task automatic drive(input bit v, input logic [PKT_W-1:0] p, input bit s, input bit f);
    cplx_valid_i = v; cplx_pkt_i = p; simple_valid_i = s; flush_i = f;
    #1;
    e_ready = (q.size() < DEPTH);
`ifdef WB_HOLD_BYPASS_EN
    e_byp = (q.size() == 0) && v && !s && !f;
`else
    e_byp = 1'b0;
`endif
    e_valid = ((q.size() != 0) && !f) || e_byp;
    e_pkt   = e_byp ? p : ((q.size() != 0) ? q[0] : '0);
    e_count = 3'(q.size());
    e_ovf   = m_ovf;
  endtask

  task automatic tick();
    if (cplx_valid_i && !e_ready) m_ovf = 1'b1;
    if (flush_i) q.delete();
    else begin
      if (q.size() != 0 && !simple_valid_i) void'(q.pop_front());
      if (cplx_valid_i && e_ready && !e_byp) q.push_back(cplx_pkt_i);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; q.delete(); m_ovf = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #3;
    checks++;
    if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {1'b0, 64'h0, 1'b1, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got v=%b p=%h r=%b c=%0d o=%b exp v=0 p=0 r=1 c=0 o=0",
               wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [PKT_W-1:0] a = 64'h1234;
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, a, 1'b0, 1'b0);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {e_valid, e_pkt, e_ready, e_count, e_ovf}) begin
        fails++;
        $display("FAIL single c=%0d got v=%b p=%h c=%0d exp v=%b p=%h c=%0d", c, wb_valid_o, wb_pkt_o, count_o, e_valid, e_pkt, e_count);
      end
`ifdef WB_HOLD_BYPASS_EN
      if (c == 0) begin
        checks++;
        if (!(wb_valid_o === 1'b1 && wb_pkt_o === a)) begin
          fails++; $display("FAIL single_bypass got v=%b p=%h exp v=1 p=%h", wb_valid_o, wb_pkt_o, a);
        end
      end
`else
      if (c == 1) begin
        checks++;
        if (!(wb_valid_o === 1'b1 && wb_pkt_o === a)) begin
          fails++; $display("FAIL single_latency got v=%b p=%h exp v=1 p=%h", wb_valid_o, wb_pkt_o, a);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] got[$];
    int idx = 0;
    for (int c = 0; c < 20; c++) begin
      bit s = (c < 8);
      bit v = (idx < 5) && (q.size() < DEPTH);
      drive(v, 64'hA + 64'(idx), s, 1'b0);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {e_valid, e_pkt, e_ready, e_count, e_ovf}) begin
        fails++;
        $display("FAIL backpressure c=%0d got v=%b p=%h r=%b c=%0d o=%b exp v=%b p=%h r=%b c=%0d o=%b", c,
                 wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o, e_valid, e_pkt, e_ready, e_count, e_ovf);
      end
      if (c == 7) begin
        checks++;
        if (count_o !== 3'd4 || cplx_ready_o !== 1'b0) begin
          fails++; $display("FAIL backpressure_full got c=%0d r=%b exp c=4 r=0", count_o, cplx_ready_o);
        end
      end
      if (wb_valid_o && !s) got.push_back(wb_pkt_o);
      if (v) idx++;
      tick();
    end
    checks++;
    if (got.size() != 5 || got[0] !== 64'hA || got[1] !== 64'hB || got[2] !== 64'hC ||
        got[3] !== 64'hD || got[4] !== 64'hE || overflow_o !== 1'b0) begin
      fails++; $display("FAIL backpressure_order got n=%0d o=%b exp n=5 A..E o=0", got.size(), overflow_o);
    end
  endtask

  task automatic test_wrap();
    logic [PKT_W-1:0] got[$];
    int idx = 0, maxc = 0;
    for (int c = 0; c < 30; c++) begin
      bit s = c[0];
      bit v = (idx < 10) && (q.size() < DEPTH);
      drive(v, 64'(idx), s, 1'b0);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o} !== {e_valid, e_pkt, e_ready, e_count}) begin
        fails++;
        $display("FAIL wrap c=%0d got v=%b p=%h c=%0d exp v=%b p=%h c=%0d", c, wb_valid_o, wb_pkt_o, count_o, e_valid, e_pkt, e_count);
      end
      if (int'(count_o) > maxc) maxc = int'(count_o);
      if (wb_valid_o && !s) got.push_back(wb_pkt_o);
      if (v) idx++;
      tick();
    end
    checks++;
    if (got.size() != 10 || maxc > DEPTH) begin
      fails++; $display("FAIL wrap_count got n=%0d maxc=%0d exp n=10 maxc<=4", got.size(), maxc);
    end else
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] !== 64'(i)) begin
          fails++; $display("FAIL wrap_order i=%0d got %h exp %h", i, got[i], 64'(i));
        end
      end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin drive(1'b1, 64'h100 + 64'(c), 1'b1, 1'b0); tick(); end
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 64'hDEAD, 1'b0, c == 0);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {e_valid, e_pkt, e_ready, e_count, e_ovf}) begin
        fails++;
        $display("FAIL flush c=%0d got v=%b p=%h c=%0d exp v=%b p=%h c=%0d", c, wb_valid_o, wb_pkt_o, count_o, e_valid, e_pkt, e_count);
      end
      if (c == 0) begin
        checks++;
        if (wb_valid_o !== 1'b0 || count_o !== 3'd3) begin
          fails++; $display("FAIL flush_cycle got v=%b c=%0d exp v=0 c=3", wb_valid_o, count_o);
        end
      end
      if (c == 1) begin
        checks++;
        if (count_o !== 3'd0 || wb_pkt_o === 64'hDEAD) begin
          fails++; $display("FAIL flush_next got c=%0d p=%h exp c=0 p!=dead", count_o, wb_pkt_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_violation();
    for (int c = 0; c < 4; c++) begin drive(1'b1, 64'h200 + 64'(c), 1'b1, 1'b0); tick(); end
    drive(1'b1, 64'hBAD, 1'b1, 1'b0);
    tick();
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
      fails++; $display("FAIL violation_flag got o=%b c=%0d exp o=1 c=4", overflow_o, count_o);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {e_valid, e_pkt, e_ready, e_count, e_ovf}) begin
        fails++;
        $display("FAIL violation_drain c=%0d got v=%b p=%h c=%0d o=%b exp v=%b p=%h c=%0d o=%b", c,
                 wb_valid_o, wb_pkt_o, count_o, overflow_o, e_valid, e_pkt, e_count, e_ovf);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin drive(1'b1, 64'h300 + 64'(c), 1'b1, 1'b0); tick(); end
    drive(1'b0, '0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0;
    checks++;
    if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {1'b0, 64'h0, 1'b1, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid got v=%b p=%h r=%b c=%0d o=%b exp v=0 p=0 r=1 c=0 o=0",
               wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o);
    end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit s = ($urandom_range(0, 2) == 0);
      bit f = ($urandom_range(0, 24) == 0);
      bit v = ($urandom_range(0, 3) != 0) && ((q.size() < DEPTH) || ($urandom_range(0, 60) == 0));
      drive(v, {$urandom, $urandom}, s, f);
      checks++;
      if ({wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o} !== {e_valid, e_pkt, e_ready, e_count, e_ovf}) begin
        fails++;
        $display("FAIL random c=%0d got v=%b p=%h r=%b c=%0d o=%b exp v=%b p=%h r=%b c=%0d o=%b", c,
                 wb_valid_o, wb_pkt_o, cplx_ready_o, count_o, overflow_o, e_valid, e_pkt, e_ready, e_count, e_ovf);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_flush();
    test_violation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
